// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state, mode encodings and default timings for the lane phase sequencer
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_GREEN = 2'd1,
        ST_EMG   = 2'd2,
        ST_PED   = 2'd3
    } state_e;

    localparam logic [1:0] MODE_DAY   = 2'b00;
    localparam logic [1:0] MODE_NIGHT = 2'b01;
    localparam logic [1:0] MODE_EMG   = 2'b10;
    localparam logic [1:0] MODE_PED   = 2'b11;

    localparam int DEF_LANES       = 8;
    localparam int DEF_CNT_W       = 7;
    localparam int DEF_GREEN_DAY   = 20;
    localparam int DEF_GREEN_NIGHT = 10;
    localparam int DEF_CLEAR_CYC   = 3;
    localparam int DEF_PED_CYC     = 15;
    localparam int DEF_NIGHT_START = 20;
    localparam int DEF_NIGHT_END   = 6;

    // Night window wraps midnight, so it is an OR of the two bounds.
    function automatic logic is_night(input logic [4:0] hour, input int start_h, input int end_h);
        return (int'(hour) >= start_h) || (int'(hour) < end_h);
    endfunction

endpackage

// File: rtl/rr_lane_picker.sv
// rtl/rr_lane_picker.sv - combinational pick of the first request strictly after a pointer, pointer last
module rr_lane_picker #(
    parameter int LANES = 8,
    parameter int IDX_W = $clog2(LANES)
) (
    input  logic [IDX_W-1:0] ptr,
    input  logic [LANES-1:0] req,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    int               idx;
    logic [IDX_W-1:0] cand;

    // With ptr = LANES-1 the scan starts at lane 0, giving lowest-index priority.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int k = 1; k <= LANES; k++) begin
            idx = int'(ptr) + k;
            if (idx >= LANES) begin
                idx = idx - LANES;
            end
            cand = IDX_W'(idx);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/lane_phase_sequencer.sv
// rtl/lane_phase_sequencer.sv - lane signal sequencer with clearance, emergency and pedestrian phases
module lane_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int LANES       = DEF_LANES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GREEN_DAY   = DEF_GREEN_DAY,
    parameter int GREEN_NIGHT = DEF_GREEN_NIGHT,
    parameter int CLEAR_CYC   = DEF_CLEAR_CYC,
    parameter int PED_CYC     = DEF_PED_CYC,
    parameter int NIGHT_START = DEF_NIGHT_START,
    parameter int NIGHT_END   = DEF_NIGHT_END
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       hoursIn,
    input  logic             pedSignal,
    input  logic             emgSignal,
    input  logic [LANES-1:0] emgLane,
    input  logic [LANES-1:0] laneDemand,
    output logic [LANES-1:0] trafficLightOutput,
    output logic [LANES-1:0] walkingLightOutput,
    output logic [1:0]       trafficMode,
    output logic [CNT_W-1:0] currentCount
);

    localparam int              IDX_W      = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD  = CNT_W'(CLEAR_CYC - 1);
    localparam logic [CNT_W-1:0] DAY_LD    = CNT_W'(GREEN_DAY - 1);
    localparam logic [CNT_W-1:0] NIGHT_LD  = CNT_W'(GREEN_NIGHT - 1);
    localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [LANES-1:0] light_q, light_d;
    logic [LANES-1:0] walk_q, walk_d;
    logic [1:0]       mode_q, mode_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             ped_q, ped_d;

    logic [IDX_W-1:0] rr_grant, emg_grant;
    logic             rr_valid, emg_valid;
    logic             emg_active, to_clear;

    rr_lane_picker #(.LANES(LANES), .IDX_W(IDX_W)) u_rr_pick (
        .ptr   (ptr_q),
        .req   (laneDemand),
        .grant (rr_grant),
        .valid (rr_valid)
    );

    rr_lane_picker #(.LANES(LANES), .IDX_W(IDX_W)) u_emg_pick (
        .ptr   (LAST_LANE),
        .req   (emgLane),
        .grant (emg_grant),
        .valid (emg_valid)
    );

    assign emg_active = emgSignal && emg_valid;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        light_d  = light_q;
        walk_d   = walk_q;
        mode_d   = mode_q;
        ptr_d    = ptr_q;
        ped_d    = ped_q | pedSignal;
        to_clear = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else if (emg_active) begin
                    state_d = ST_EMG;
                    count_d = '0;
                    light_d = LANES'(1) << emg_grant;
                    mode_d  = MODE_EMG;
                end else if (ped_q || pedSignal) begin
                    state_d = ST_PED;
                    count_d = PED_LD;
                    light_d = '0;
                    walk_d  = '1;
                    mode_d  = MODE_PED;
                    ped_d   = 1'b0;
                end else if (rr_valid) begin
                    state_d = ST_GREEN;
                    ptr_d   = rr_grant;
                    light_d = LANES'(1) << rr_grant;
                    // Hour is sampled here only; the green keeps its length and mode.
                    if (is_night(hoursIn, NIGHT_START, NIGHT_END)) begin
                        count_d = NIGHT_LD;
                        mode_d  = MODE_NIGHT;
                    end else begin
                        count_d = DAY_LD;
                        mode_d  = MODE_DAY;
                    end
                end else begin
                    count_d = CLEAR_LD;
                end
            end
            ST_GREEN: begin
                if (emg_active) begin
                    if ((emgLane & light_q) != '0) begin
                        state_d = ST_EMG;
                        count_d = '0;
                        mode_d  = MODE_EMG;
                    end else begin
                        to_clear = 1'b1;
                    end
                end else if (count_q == '0) begin
                    to_clear = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            ST_EMG: begin
                if (!emgSignal || ((emgLane & light_q) == '0)) begin
                    to_clear = 1'b1;
                end
            end
            ST_PED: begin
                if (emg_active || (count_q == '0)) begin
                    to_clear = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: to_clear = 1'b1;
        endcase
        if (to_clear) begin
            state_d = ST_CLEAR;
            count_d = CLEAR_LD;
            light_d = '0;
            walk_d  = '0;
            mode_d  = MODE_DAY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_CLEAR;
            count_q <= CLEAR_LD;
            light_q <= '0;
            walk_q  <= '0;
            mode_q  <= MODE_DAY;
            ptr_q   <= LAST_LANE;
            ped_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            light_q <= light_d;
            walk_q  <= walk_d;
            mode_q  <= mode_d;
            ptr_q   <= ptr_d;
            ped_q   <= ped_d;
        end
    end

    assign trafficLightOutput = light_q;
    assign walkingLightOutput = walk_q;
    assign trafficMode        = mode_q;
    assign currentCount       = count_q;

endmodule

// File: doc/lane_phase_sequencer.md
LANE_PHASE_SEQUENCER -- requirements
Module: lane_phase_sequencer

Interface
REQ-001 Parameter LANES, default 8: number of signal-controlled lanes (2..16).
REQ-002 Parameter CNT_W, default 7: countdown width; every timing parameter SHALL be less than 2^CNT_W.
REQ-003 Parameters GREEN_DAY=20, GREEN_NIGHT=10, CLEAR_CYC=3, PED_CYC=15: phase lengths in clock cycles, each >= 1.
REQ-004 Parameters NIGHT_START=20, NIGHT_END=6: night window in hours.
REQ-005 clk  input  1  rising-edge clock; the only clock.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 hoursIn  input  5  hour of day, 0..23.
REQ-008 pedSignal  input  1  pedestrian request; a one-cycle pulse is sufficient.
REQ-009 emgSignal  input  1  emergency vehicle present.
REQ-010 emgLane  input  LANES  lanes holding an emergency vehicle; lowest set index wins.
REQ-011 laneDemand  input  LANES  bit i high means lane i has queued cars.
REQ-012 trafficLightOutput  output  LANES  one-hot or zero; bit i high means lane i is green.
REQ-013 walkingLightOutput  output  LANES  crosswalk walk lights.
REQ-014 trafficMode  output  2  00 day, 01 night, 10 emergency, 11 pedestrian.
REQ-015 currentCount  output  CNT_W  remaining cycles in the current phase.

Function
REQ-016 FSM states SHALL be CLEAR (all red), GREEN, EMG and PED, with all outputs registered.
REQ-017 CLEAR SHALL load CLEAR_CYC-1, decrement each cycle, and decide at count 0 with this priority: emergency, then pedestrian latch, then round-robin demand.
REQ-018 Emergency entry (emgSignal=1 and emgLane!=0) SHALL go to EMG, granting the lowest set emgLane index.
REQ-019 Pedestrian entry SHALL go to PED, load PED_CYC-1, drive trafficLightOutput=0, and drive walkingLightOutput all ones.
REQ-020 Round-robin SHALL grant the first laneDemand bit strictly after the pointer, wrapping at LANES-1; the pointer is included last.
REQ-021 Round-robin SHALL update the pointer to the granted lane, and EMG grants SHALL NOT move the pointer.
REQ-022 With no emergency, no pedestrian request and laneDemand=0, CLEAR SHALL reload CLEAR_CYC-1 and remain all red.
REQ-023 GREEN SHALL load GREEN_NIGHT-1 when hoursIn>=NIGHT_START or hoursIn<NIGHT_END, else GREEN_DAY-1.
REQ-024 In GREEN, hoursIn SHALL be sampled at entry only, and trafficMode SHALL be 01 or 00 accordingly.
REQ-025 GREEN SHALL decrement to 0 and then enter CLEAR.
REQ-026 Emergency during GREEN with the current lane set in emgLane SHALL convert to EMG on the next cycle, keeping the same light.
REQ-027 Emergency during GREEN with the current lane not set in emgLane SHALL abort to CLEAR on the next cycle.
REQ-028 EMG SHALL hold the granted green with currentCount=0 and trafficMode=10.
REQ-029 EMG SHALL exit to CLEAR on the cycle after emgSignal=0 or after the granted emgLane bit clears.
REQ-030 PED SHALL count to 0 and then enter CLEAR; emergency during PED SHALL abort to CLEAR on the next cycle.
REQ-031 The pedestrian latch SHALL set on any pedSignal high and clear on PED entry; pedSignal high in the entry cycle SHALL be absorbed.
REQ-032 At most one trafficLightOutput bit SHALL be high, and walk lights SHALL never be lit together with any green.

Reset
REQ-033 While rst=0: state CLEAR, currentCount=CLEAR_CYC-1, trafficLightOutput=0, walkingLightOutput=0, trafficMode=00, pointer=LANES-1, pedestrian latch=0.
REQ-034 Reset assertion mid-phase SHALL take effect immediately, without waiting for a clock edge.

Structure
REQ-035 Package traffic_pkg SHALL hold the state enum, the trafficMode encodings and the default timing constants.
REQ-036 Sub-module rr_lane_picker (combinational: pointer and request mask in; grant index and valid out) SHALL implement both the round-robin and the lowest-index selection.

Verification
REQ-037 Reset then laneDemand=8'b00000101, hoursIn=12 -> 3 all-red cycles, lane0 green for 20 cycles (count 19..0), 3 red, lane2 green, then lane0 again.
REQ-038 hoursIn=22, laneDemand=8'b10000000 -> lane7 green for 10 cycles with trafficMode=01, then 3 red, repeating.
REQ-039 Lane0 green at count 15, then emgSignal=1, emgLane=8'b00001000 -> CLEAR next cycle; after 3 cycles lane3 green with mode 10.
REQ-040 (continues REQ-039) Lane3 SHALL hold until emgSignal drops, then 3 red cycles, then the next demand lane after lane0.
REQ-041 One-cycle pedSignal during green -> after green and CLEAR: walk all ones, lights 0, mode 11, count 14..0; then CLEAR; no second PED.
REQ-042 laneDemand=0 -> all red, count cycling 2,1,0 indefinitely.
REQ-043 rst=0 asserted mid-phase -> all outputs at REQ-033 values with no clock edge required.
